// File: rtl/logic_unit_arbiter_if.sv
// Bus bundle between the requesters, the arbiter and the shared logic unit.
//   req/op_a/op_b/op_sel : per-requester request level and packed operands/opcode
//   gnt/done/busy        : one-hot grant, one-hot completion pulse, arbiter busy flag
//   result               : last captured logic-unit result
//   lu_a/lu_b/lu_op      : registered operands/opcode presented to the logic unit
//   lu_y                 : combinational result coming back from the logic unit
// The slave modport is the arbiter; the master modport is everything around it
// (requesters plus the external gate array).
interface logic_unit_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] op_a;
    logic [N_REQ*WIDTH-1:0] op_b;
    logic [2*N_REQ-1:0]     op_sel;
    logic [N_REQ-1:0]       gnt;
    logic [WIDTH-1:0]       lu_a;
    logic [WIDTH-1:0]       lu_b;
    logic [1:0]             lu_op;
    logic [WIDTH-1:0]       lu_y;
    logic [WIDTH-1:0]       result;
    logic [N_REQ-1:0]       done;
    logic                   busy;

    modport slave (
        input  req, op_a, op_b, op_sel, lu_y,
        output gnt, lu_a, lu_b, lu_op, result, done, busy
    );

    modport master (
        output req, op_a, op_b, op_sel, lu_y,
        input  gnt, lu_a, lu_b, lu_op, result, done, busy
    );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational logic unit between
// N_REQ requesters. A winner's operands are registered onto the logic unit,
// held stable for LAT cycles, the unit output is captured into result and a
// one-cycle done pulse is returned to the winner.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : logic_unit_arbiter_if slave modport (requests, operands, grant,
//          done, busy, result, and the logic-unit operand/result wires)
module logic_unit_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int LAT   = 2
) (
    input logic                  clk,
    input logic                  rst,
    logic_unit_arbiter_if.slave  bus
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   winner_q, winner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   lu_a_q, lu_a_d;
    logic [WIDTH-1:0]   lu_b_q, lu_b_d;
    logic [1:0]         lu_op_q, lu_op_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic               found;
    logic [PTR_W-1:0]   pick;
    int                 idx;
    logic [N_REQ-1:0]   win_onehot;

    // Round-robin search: scan from ptr upward with wrap and take the first
    // requester whose req is set. The index is kept in range by subtracting
    // N_REQ once, which is enough since ptr < N_REQ and i < N_REQ.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                pick  = idx[PTR_W-1:0];
            end
        end
    end

    // Sequencer next-state logic. Operands are only loaded on the IDLE->HOLD
    // edge, so anything the requesters do during HOLD/DONE cannot disturb the
    // logic-unit inputs, and they keep their last value afterwards so the
    // gate array does not toggle needlessly. The hold counter starts at LAT-1
    // so HOLD lasts exactly LAT cycles and the result is captured on the last.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        winner_d = winner_q;
        cnt_d    = cnt_q;
        lu_a_d   = lu_a_q;
        lu_b_d   = lu_b_q;
        lu_op_d  = lu_op_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    winner_d = pick;
                    lu_a_d   = bus.op_a[int'(pick)*WIDTH +: WIDTH];
                    lu_b_d   = bus.op_b[int'(pick)*WIDTH +: WIDTH];
                    lu_op_d  = bus.op_sel[int'(pick)*2 +: 2];
                    cnt_d    = CNT_W'(LAT - 1);
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    result_d = bus.lu_y;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (winner_q == PTR_W'(N_REQ - 1)) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = winner_q + 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight,
    // so no done pulse can follow a reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            winner_q <= '0;
            cnt_q    <= '0;
            lu_a_q   <= '0;
            lu_b_q   <= '0;
            lu_op_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            winner_q <= winner_d;
            cnt_q    <= cnt_d;
            lu_a_q   <= lu_a_d;
            lu_b_q   <= lu_b_d;
            lu_op_q  <= lu_op_d;
            result_q <= result_d;
        end
    end

    // Grant and done are decoded from the registered state, so they can never
    // overlap and each is one-hot at most.
    always_comb begin
        win_onehot           = '0;
        win_onehot[winner_q] = 1'b1;
        bus.gnt  = (state_q == HOLD) ? win_onehot : '0;
        bus.done = (state_q == DONE) ? win_onehot : '0;
        bus.busy = (state_q != IDLE);
    end

    assign bus.lu_a   = lu_a_q;
    assign bus.lu_b   = lu_b_q;
    assign bus.lu_op  = lu_op_q;
    assign bus.result = result_q;

endmodule
